err_calc: RTL and testbench
===========================

Name: err_calc

Overview:
- Error-phase responder for the linear-regression datapath; it sits opposite the data loader on the en_err / err_done handshake.
- For each sample strobed by the loader, it computes residual r = y - (b0 + b1*x) in fixed point and squares it. It accumulates the sum of squared errors (SSE) over N_SAMPLES samples.
- It returns one err_done pulse per sample, so the loader advances to the next sample. It flags sse_valid when the run is complete.

Parameters:
- W, 20: sample and coefficient width, signed two's complement.
- FRAC, 10: fractional bits (Q10.10 at the default widths).
- N_SAMPLES, 150: samples per run.
- ACC_W, 48: SSE accumulator width, unsigned.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; clears the accumulator and sample count and re-arms the block. Same pulse the loader receives.
- en_err  input  1  one-cycle strobe from the loader; x_in and y_in are valid this cycle.
- x_in  input  W  sample x (loader outx).
- y_in  input  W  sample y (loader outy).
- b0  input  W  intercept, Q10.10; held stable for the whole error phase.
- b1  input  W  slope, Q10.10; held stable for the whole error phase.
- err_done  output  1  one-cycle pulse; the current sample is absorbed.
- err_val  output  W  residual of the last completed sample, Q10.10.
- sse  output  ACC_W  running SSE, Q.FRAC format.
- sample_cnt  output  8  samples completed in this run.
- sse_valid  output  1  high once sample_cnt reaches N_SAMPLES; held until start or rst.

Behaviour:
- Reset: rst forces state IDLE and clears every output: err_done=0, err_val=0, sse=0, sample_cnt=0, sse_valid=0.
  - rst asserted mid-computation discards the sample in flight; no err_done is issued for it.
- FSM states: IDLE, MUL, RES, SQR, ACC, DONE.
- IDLE:
  - On en_err, with sse_valid=0 and start=0: latch x_in and y_in, go to MUL.
  - On en_err while sse_valid=1: ignore the strobe; no err_done is issued.
- MUL: p = b1*x, 2W-bit signed product; pred = (p >>> FRAC) + sign-extended b0, held in W+2 bits. Go to RES.
- RES: r_full = sext(y) - pred, in W+2 bits; reduce r_full to W bits (truncate, or saturate per SAT_EN); load err_val. Go to SQR.
- SQR: sq = (r*r) >> FRAC, unsigned 2W-FRAC bits, using the W-bit r. Go to ACC.
- ACC: sse += zero-extended sq, modulo 2^ACC_W with no saturation; sample_cnt += 1. Go to DONE.
- DONE:
  - err_done=1 for exactly this cycle.
  - If sample_cnt == N_SAMPLES, set sse_valid=1.
  - Return to IDLE.
- Latency: en_err at cycle 0 produces err_done at cycle 5. Minimum strobe spacing is 6 cycles.
- en_err while not in IDLE is ignored, with no queueing. The loader must wait for err_done before strobing again.
- start:
  - In any state, start returns the block to IDLE and clears sse, sample_cnt, sse_valid and err_val.
  - Start overrides a simultaneous en_err; that strobe is dropped.
- sample_cnt stops at N_SAMPLES; it does not wrap.

Optional Feature:
- Macro: ERR_SAT_EN.
- Defined: in RES, if r_full exceeds the W-bit signed range, r saturates to 2^(W-1)-1 (0x7FFFF at the defaults) or -2^(W-1) (0x80000).
- Undefined: r is the low W bits of r_full (wrap-around).
- SQR and ACC always use the reduced W-bit r, so sse differs between the two builds whenever saturation occurs.

Test Plan:
- Single sample:
  - Stimulus: b1=0x00400 (1.0), b0=0, x=0x00800 (2.0), y=0x00C00 (3.0), en_err pulse.
  - Response: err_done exactly 5 cycles later; err_val=0x00400; sse=1024; sample_cnt=1.
- Negative residual:
  - Stimulus: same coefficients, x=0x00800, y=0x00400.
  - Response: err_val=0xFFC00 (-1.0); sse increments by 1024.
- Full run:
  - Stimulus: 150 samples at x=2.0, y=3.0, each strobed after the previous err_done.
  - Response: sse=153600; sse_valid rises in the DONE cycle of sample 150.
  - Follow-up: a 151st en_err produces no err_done, and sse and sample_cnt are unchanged.
- Overflow:
  - Stimulus: b1=0, b0=0x80400 (-511.0), y=0x7FC00 (511.0).
  - Response without ERR_SAT_EN: err_val=0xFF800.
  - Response with ERR_SAT_EN: err_val=0x7FFFF.
- Busy and restart:
  - Stimulus: en_err 2 cycles after a prior en_err.
  - Response: the second strobe is ignored; only one err_done is issued.
  - Follow-up: start after a completed run clears sse, sample_cnt and sse_valid to 0 in the next cycle.
- Reset mid-op:
  - Stimulus: rst pulsed 1 cycle after en_err.
  - Response: err_done never asserts; all outputs 0; the next en_err is processed normally with 5-cycle latency.

Source files
------------

// File: rtl/err_calc.sv
// Error-phase responder: per strobed sample computes r = y - (b0 + b1*x) and accumulates r^2 into the SSE.
// Optional macro ERR_SAT_EN saturates the residual to W bits instead of wrapping.
module err_calc #(
  parameter int unsigned W         = 20,
  parameter int unsigned FRAC      = 10,
  parameter int unsigned N_SAMPLES = 150,
  parameter int unsigned ACC_W     = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en_err,
  input  logic [W-1:0]     x_in,
  input  logic [W-1:0]     y_in,
  input  logic [W-1:0]     b0,
  input  logic [W-1:0]     b1,
  output logic             err_done,
  output logic [W-1:0]     err_val,
  output logic [ACC_W-1:0] sse,
  output logic [7:0]       sample_cnt,
  output logic             sse_valid
);

  localparam int unsigned PW   = 2 * W;
  localparam int unsigned SQ_W = 2 * W - FRAC;
`ifdef ERR_SAT_EN
  localparam int unsigned RES_W = W + 2;
`else
  // Wrapping keeps only the low W bits, which depend only on the low W bits of the operands.
  localparam int unsigned RES_W = W;
`endif

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MUL  = 3'd1;
  localparam logic [2:0] RES  = 3'd2;
  localparam logic [2:0] SQR  = 3'd3;
  localparam logic [2:0] ACC  = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  logic [2:0]              state;
  logic [2:0]              state_nxt;
  logic signed [W-1:0]     x_r;
  logic signed [W-1:0]     y_r;
  logic signed [RES_W-1:0] pred_r;
  logic [SQ_W-1:0]         sq_r;
  logic signed [PW-1:0]    prod_c;
  logic signed [PW-1:0]    sq_full_c;
  logic signed [RES_W-1:0] r_full_c;
  logic [W-1:0]            r_c;
  logic                    accept_c;

  assign accept_c  = (state == IDLE) && en_err && !sse_valid && !start;
  assign prod_c    = PW'($signed(b1)) * PW'(x_r);
  assign r_full_c  = RES_W'(y_r) - pred_r;
  assign sq_full_c = PW'($signed(err_val)) * PW'($signed(err_val));

  // Reduce the wide residual to W bits.
  always_comb begin
`ifdef ERR_SAT_EN
    if (r_full_c[RES_W-1:W-1] != {(RES_W-W+1){r_full_c[RES_W-1]}}) begin
      r_c = r_full_c[RES_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      r_c = r_full_c[W-1:0];
    end
`else
    r_c = r_full_c;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept_c) state_nxt = MUL;
        MUL:     state_nxt = RES;
        RES:     state_nxt = SQR;
        SQR:     state_nxt = ACC;
        ACC:     state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r        <= '0;
      y_r        <= '0;
      pred_r     <= '0;
      sq_r       <= '0;
      err_done   <= 1'b0;
      err_val    <= '0;
      sse        <= '0;
      sample_cnt <= '0;
      sse_valid  <= 1'b0;
    end else if (start) begin
      err_done   <= 1'b0;
      err_val    <= '0;
      sse        <= '0;
      sample_cnt <= '0;
      sse_valid  <= 1'b0;
    end else begin
      err_done <= (state == ACC);
      case (state)
        IDLE: begin
          if (accept_c) begin
            x_r <= x_in;
            y_r <= y_in;
          end
        end
        MUL:  pred_r  <= RES_W'(prod_c >>> FRAC) + RES_W'($signed(b0));
        RES:  err_val <= r_c;
        SQR:  sq_r    <= SQ_W'(sq_full_c >> FRAC);
        ACC: begin
          sse <= sse + ACC_W'(sq_r);
          if (sample_cnt != 8'(N_SAMPLES)) sample_cnt <= sample_cnt + 8'd1;
          if (sample_cnt + 8'd1 == 8'(N_SAMPLES)) sse_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_err_calc.sv
// Randomized self-checking bench for err_calc against an arithmetic reference model.
module tb_err_calc;

  localparam int W     = 20;
  localparam int FRAC  = 10;
  localparam int N     = 150;
  localparam int ACC_W = 48;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             en_err;
  logic [W-1:0]     x_in;
  logic [W-1:0]     y_in;
  logic [W-1:0]     b0;
  logic [W-1:0]     b1;
  logic             err_done;
  logic [W-1:0]     err_val;
  logic [ACC_W-1:0] sse;
  logic [7:0]       sample_cnt;
  logic             sse_valid;

  int     vectors     = 0;
  int     miscompares = 0;
  longint m_sse;
  int     m_cnt;
  bit     m_valid;
  longint m_err;

  err_calc dut (
    .clk(clk), .rst(rst), .start(start), .en_err(en_err),
    .x_in(x_in), .y_in(y_in), .b0(b0), .b1(b1),
    .err_done(err_done), .err_val(err_val), .sse(sse),
    .sample_cnt(sample_cnt), .sse_valid(sse_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Interpret the low 'bits' of v as a two's complement number.
  function automatic longint sx(input longint v, input int bits);
    longint t;
    t = v & ((longint'(1) << bits) - 1);
    if (((t >> (bits - 1)) & 1) != 0) t = t - (longint'(1) << bits);
    return t;
  endfunction

  function automatic longint model_res(input logic [W-1:0] xv, input logic [W-1:0] yv);
    longint p, pred, rf, r;
    p    = sx(longint'(b1), W) * sx(longint'(xv), W);
    pred = sx((p >>> FRAC) + sx(longint'(b0), W), W + 2);
    rf   = sx(sx(longint'(yv), W) - pred, W + 2);
`ifdef ERR_SAT_EN
    if (rf > 524287)       r = 524287;
    else if (rf < -524288) r = -524288;
    else                   r = rf;
`else
    r = sx(rf, W);
`endif
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, " err_val"}, 64'(err_val), 64'(m_err));
    check({tag, " sse"}, 64'(sse), 64'(m_sse));
    check({tag, " sample_cnt"}, 64'(sample_cnt), 64'(m_cnt));
    check({tag, " sse_valid"}, 64'(sse_valid), 64'(m_valid));
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    m_sse = 0; m_cnt = 0; m_valid = 1'b0; m_err = 0;
  endtask

  task automatic do_sample(input logic [W-1:0] xv, input logic [W-1:0] yv, input string tag);
    int     lat;
    int     pulses;
    bit     expect_done;
    bit     sv4, sv5;
    longint r;
    lat = -1; pulses = 0; sv4 = 1'b0; sv5 = 1'b0;
    expect_done = !m_valid;
    @(negedge clk); x_in = xv; y_in = yv; en_err = 1'b1;
    @(negedge clk); en_err = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      if (err_done) begin
        pulses++;
        if (lat < 0) lat = n;
      end
      if (n == 4) sv4 = sse_valid;
      if (n == 5) sv5 = sse_valid;
      @(negedge clk);
    end
    if (expect_done) begin
      r       = model_res(xv, yv);
      m_err   = r & 64'hFFFFF;
      m_sse   = (m_sse + ((r * r) >> FRAC)) & ((longint'(1) << ACC_W) - 1);
      m_cnt   = m_cnt + 1;
      m_valid = (m_cnt == N);
      check({tag, " latency"}, 64'(lat), 64'd5);
      check({tag, " valid_pre"}, 64'(sv4), 64'd0);
      check({tag, " valid_done"}, 64'(sv5), 64'(m_valid));
    end
    check({tag, " pulses"}, 64'(pulses), expect_done ? 64'd1 : 64'd0);
    check_outputs(tag);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; en_err = 1'b0;
    x_in = '0; y_in = '0; b0 = '0; b1 = '0;
    m_sse = 0; m_cnt = 0; m_valid = 1'b0; m_err = 0;
    repeat (3) @(negedge clk);
    check("reset err_done", 64'(err_done), 64'd0);
    check_outputs("reset");
    rst = 1'b0;

    // Single sample and negative residual.
    b1 = 20'h00400; b0 = 20'h00000;
    pulse_start();
    do_sample(20'h00800, 20'h00C00, "single");
    check("single const err_val", 64'(err_val), 64'h00400);
    check("single const sse", 64'(sse), 64'd1024);
    do_sample(20'h00800, 20'h00400, "negative");
    check("negative const err_val", 64'(err_val), 64'hFFC00);
    check("negative const sse", 64'(sse), 64'd2048);

    // Randomized coefficients and samples, full range and small range.
    pulse_start();
    for (int i = 0; i < 30; i++) begin
      if (i % 5 == 0) begin
        if (i % 10 == 0) begin
          b0 = W'($urandom);
          b1 = W'($urandom);
        end else begin
          b0 = W'(sx(longint'($urandom_range(0, 8191)) - 4096, W));
          b1 = W'(sx(longint'($urandom_range(0, 4095)) - 2048, W));
        end
      end
      do_sample(W'($urandom), W'($urandom), "random");
    end

    // Overflow of the residual.
    pulse_start();
    b1 = 20'h00000; b0 = 20'h80400;
    do_sample(W'($urandom), 20'h7FC00, "overflow");
`ifdef ERR_SAT_EN
    check("overflow const err_val", 64'(err_val), 64'h7FFFF);
`else
    check("overflow const err_val", 64'(err_val), 64'hFF800);
`endif

    // Full run, then a strobe that must be ignored, then restart.
    b1 = 20'h00400; b0 = 20'h00000;
    pulse_start();
    for (int i = 0; i < N; i++) do_sample(20'h00800, 20'h00C00, "full");
    check("full const sse", 64'(sse), 64'd153600);
    check("full const sse_valid", 64'(sse_valid), 64'd1);
    do_sample(20'h00800, 20'h00C00, "extra");
    check("extra const sample_cnt", 64'(sample_cnt), 64'd150);
    pulse_start();
    check_outputs("restart");
    check("restart const sse", 64'(sse), 64'd0);

    // Busy: second strobe two cycles after the first is dropped.
    pulses = 0;
    @(negedge clk); x_in = 20'h00800; y_in = 20'h00C00; en_err = 1'b1;
    @(negedge clk); en_err = 1'b0;
    @(negedge clk); x_in = 20'h01000; y_in = 20'h00000; en_err = 1'b1;
    @(negedge clk); en_err = 1'b0;
    for (int n = 0; n < 14; n++) begin
      if (err_done) pulses++;
      @(negedge clk);
    end
    m_err = 64'h00400; m_sse = 1024; m_cnt = 1; m_valid = 1'b0;
    check("busy pulses", 64'(pulses), 64'd1);
    check_outputs("busy");

    // Reset in flight.
    pulses = 0;
    @(negedge clk); x_in = 20'h00800; y_in = 20'h00C00; en_err = 1'b1;
    @(negedge clk); en_err = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (err_done) pulses++;
      @(negedge clk);
    end
    m_sse = 0; m_cnt = 0; m_valid = 1'b0; m_err = 0;
    check("rstmid pulses", 64'(pulses), 64'd0);
    check_outputs("rstmid");
    do_sample(20'h00800, 20'h00C00, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
